uart_rx_ctrl: RTL

//  Receive-side sequencer for the UART: synchronises the serial line, detects start bit,

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_baud_cnt.sv | 34 +++
 rtl/uart_rx_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: data word, receive sequencer states, default bit period.
// Imported by the receive controller and its baud counter.
package uart_pkg;

   localparam int W_DATA           = 8;
   localparam int CLK_PER_BIT_DFLT = 16;

   typedef logic [W_DATA-1:0] data_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

endpackage

// File: rtl/uart_rx_baud_cnt.sv
// Bit-period timer: counts 0..N-1 and wraps, with flags at the half-period and full-period terminal counts.
// Latency: flags are decoded from the count register; no backpressure, clr holds the count at 0.
module uart_rx_baud_cnt
   import uart_pkg::*;
#(
   parameter int N = CLK_PER_BIT_DFLT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic mid,
   output logic full
);

   localparam int             W      = $clog2(N);
   localparam logic [W-1:0]   MID_V  = W'(N/2 - 1);
   localparam logic [W-1:0]   FULL_V = W'(N - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr || full) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

   assign mid  = (cnt == MID_V);
   assign full = (cnt == FULL_V);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: syncs rx, finds the start bit, pulses sipo shift at bit centres, checks parity/stop.
// Latency: strobe about 10.5 bit periods + sync after the start edge; no backpressure, frames are never stalled.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = CLK_PER_BIT_DFLT,
   parameter bit PARITY_EN   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   input  logic sipo_par,
   output logic rx_bit,
   output logic shift_en,
   output logic busy,
   output logic rx_valid,
   output logic parity_err,
   output logic frame_err
);

   localparam int             BW       = $clog2(W_DATA + 1);
   localparam logic [BW-1:0]  LAST_BIT = BW'(W_DATA - 1);

   rx_state_e     state, state_nxt;
   logic [BW-1:0] bit_cnt, bit_cnt_nxt;
   logic          rx_s1, rx_d;
   logic          par_bit, par_bit_nxt;
   logic          rx_valid_nxt, parity_err_nxt, frame_err_nxt;
   logic          baud_clr, baud_mid, baud_full;

   // Sync chain presets to the idle level so reset never looks like a start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_s1  <= 1'b1;
         rx_bit <= 1'b1;
         rx_d   <= 1'b1;
      end else begin
         rx_s1  <= rx;
         rx_bit <= rx_s1;
         rx_d   <= rx_bit;
      end
   end

   uart_rx_baud_cnt #(
      .N (CLK_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clr  (baud_clr),
      .mid  (baud_mid),
      .full (baud_full)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         par_bit    <= 1'b0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         par_bit    <= par_bit_nxt;
         rx_valid   <= rx_valid_nxt;
         parity_err <= parity_err_nxt;
         frame_err  <= frame_err_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      bit_cnt_nxt    = bit_cnt;
      par_bit_nxt    = par_bit;
      rx_valid_nxt   = 1'b0;
      parity_err_nxt = parity_err;
      frame_err_nxt  = frame_err;
      baud_clr       = 1'b0;
      shift_en       = 1'b0;
      case (state)
         IDLE: begin
            baud_clr = 1'b1;
            if (!rx_bit && rx_d) state_nxt = START;
         end
         START: begin
            // Half-period check: a start bit that has gone high again was a glitch.
            if (baud_mid) begin
               baud_clr = 1'b1;
               if (!rx_bit) begin
                  state_nxt   = DATA;
                  bit_cnt_nxt = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         DATA: begin
            if (baud_full) begin
               shift_en    = 1'b1;
               bit_cnt_nxt = bit_cnt + BW'(1);
               if (bit_cnt == LAST_BIT) state_nxt = PARITY_EN ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (baud_full) begin
               par_bit_nxt = rx_bit;
               state_nxt   = STOP;
            end
         end
         STOP: begin
            // Leave mid stop bit so a back-to-back start edge is caught.
            if (baud_full) begin
               rx_valid_nxt   = 1'b1;
               frame_err_nxt  = ~rx_bit;
               parity_err_nxt = PARITY_EN ? (par_bit ^ sipo_par) : 1'b0;
               state_nxt      = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule
